seqdet_rr_scheduler: RTL and testbench

//  Shares one bit-serial Moore pattern detector (PAT_W-bit shift window vs. pattern) among N_REQ requesters.

---
 rtl/seqdet_rr_scheduler_if.sv | 46 ++++
 rtl/seqdet_rr_scheduler.sv | 166 ++++++++++++++++
 tb/tb_seqdet_rr_scheduler.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seqdet_rr_scheduler_if.sv
// Interface for seqdet_rr_scheduler: groups the requester-side word handshake,
// the pattern input, the result handshake and the status/observation outputs.
//   master : the environment (word producers + result consumer)
//   slave  : the scheduler itself
// Signals:
//   pattern   PAT_W         target pattern, latched at grant
//   req_valid N_REQ         per-requester word available
//   req_data  N_REQ*WORD_W  requester i word at [i*WORD_W +: WORD_W]
//   req_ready N_REQ         one-hot, one-cycle accept pulse
//   busy      1             scheduler is shifting or reporting
//   window    PAT_W         current detector shift window
//   res_valid 1             result available, held until res_ready
//   res_id    ID_W          granted requester index
//   res_count CNT_W         matches found in this word (saturating)
//   res_hit   1             res_count != 0
//   res_ready 1             consumer accepts result
interface seqdet_rr_scheduler_if #(
    parameter int N_REQ  = 4,
    parameter int WORD_W = 8,
    parameter int PAT_W  = 4,
    parameter int CNT_W  = 4
);
    localparam int ID_W = $clog2(N_REQ);

    logic [PAT_W-1:0]        pattern;
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*WORD_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic                    busy;
    logic [PAT_W-1:0]        window;
    logic                    res_valid;
    logic [ID_W-1:0]         res_id;
    logic [CNT_W-1:0]        res_count;
    logic                    res_hit;
    logic                    res_ready;

    modport master (
        output pattern, req_valid, req_data, res_ready,
        input  req_ready, busy, window, res_valid, res_id, res_count, res_hit
    );

    modport slave (
        input  pattern, req_valid, req_data, res_ready,
        output req_ready, busy, window, res_valid, res_id, res_count, res_hit
    );
endinterface

// File: rtl/seqdet_rr_scheduler.sv
// seqdet_rr_scheduler: one bit-serial Moore pattern detector shared by N_REQ
// requesters. A round-robin arbiter grants one word, the word is shifted MSB
// first through a PAT_W-bit window, matches against the latched pattern are
// counted (saturating) and the count/hit/id is offered on a valid/ready port.
// Ports:
//   clk    in  clock, all logic on posedge
//   reset  in  synchronous, active-high
//   bus    seqdet_rr_scheduler_if.slave (request, pattern, result handshakes)
// Build option:
//   SEQDET_HIST_CLEAR_EN  defined: window and fill cleared at every grant, so a
//                         match never spans two words. Undefined: history
//                         persists across grants and is cleared only by reset.
module seqdet_rr_scheduler #(
    parameter int N_REQ  = 4,
    parameter int WORD_W = 8,
    parameter int PAT_W  = 4,
    parameter int CNT_W  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    seqdet_rr_scheduler_if.slave bus
);
    localparam int ID_W   = $clog2(N_REQ);
    localparam int BIT_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int FILL_W = $clog2(PAT_W + 1);

    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [BIT_W-1:0]  BIT_TOP   = BIT_W'(WORD_W - 1);
    localparam logic [ID_W-1:0]   LAST_RST  = ID_W'(N_REQ - 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_REPORT} state_t;

    state_t              state_q,   state_d;
    logic [WORD_W-1:0]   data_q,    data_d;
    logic [PAT_W-1:0]    pat_q,     pat_d;
    logic [ID_W-1:0]     id_q,      id_d;
    logic [CNT_W-1:0]    count_q,   count_d;
    logic [BIT_W-1:0]    bit_idx_q, bit_idx_d;
    logic [PAT_W-1:0]    window_q,  window_d;
    logic [FILL_W-1:0]   fill_q,    fill_d;
    logic [ID_W-1:0]     last_q,    last_d;

    logic                gnt_found;
    logic [ID_W-1:0]     gnt_idx;
    logic [N_REQ-1:0]    req_ready_w;
    logic [PAT_W-1:0]    win_next;
    logic [FILL_W-1:0]   fill_next;
    logic                match;

    // Round-robin search starting one past the last grant; last_q resets to
    // N_REQ-1 so requester 0 has top priority out of reset.
    always_comb begin
        int unsigned  cand;
        logic [ID_W-1:0] cidx;
        cand      = 0;
        cidx      = '0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = (32'(last_q) + k) % N_REQ;
            cidx = ID_W'(cand);
            if (!gnt_found && bus.req_valid[cidx]) begin
                gnt_found = 1'b1;
                gnt_idx   = cidx;
            end
        end
    end

    // Match is judged on the window/fill values after this cycle's shift,
    // which is what makes the detector Moore-style on the registered window.
    always_comb begin
        win_next  = {window_q[PAT_W-2:0], data_q[bit_idx_q]};
        fill_next = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
        match     = (win_next == pat_q) && (fill_next == FILL_FULL);
    end

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        pat_d     = pat_q;
        id_d      = id_q;
        count_d   = count_q;
        bit_idx_d = bit_idx_q;
        window_d  = window_q;
        fill_d    = fill_q;
        last_d    = last_q;

        unique case (state_q)
            S_IDLE: begin
                if (gnt_found) begin
                    data_d    = bus.req_data[gnt_idx*WORD_W +: WORD_W];
                    pat_d     = bus.pattern;
                    id_d      = gnt_idx;
                    last_d    = gnt_idx;
                    count_d   = '0;
                    bit_idx_d = BIT_TOP;
`ifdef SEQDET_HIST_CLEAR_EN
                    window_d  = '0;
                    fill_d    = '0;
`endif
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                window_d = win_next;
                fill_d   = fill_next;
                if (match && (count_q != '1)) begin
                    count_d = count_q + 1'b1;
                end
                if (bit_idx_q == '0) begin
                    state_d = S_REPORT;
                end else begin
                    bit_idx_d = bit_idx_q - 1'b1;
                end
            end
            S_REPORT: begin
                if (bus.res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            data_q    <= '0;
            pat_q     <= '0;
            id_q      <= '0;
            count_q   <= '0;
            bit_idx_q <= '0;
            window_q  <= '0;
            fill_q    <= '0;
            last_q    <= LAST_RST;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            pat_q     <= pat_d;
            id_q      <= id_d;
            count_q   <= count_d;
            bit_idx_q <= bit_idx_d;
            window_q  <= window_d;
            fill_q    <= fill_d;
            last_q    <= last_d;
        end
    end

    // Accept pulse is suppressed while reset is asserted: a grant in that
    // cycle would be discarded by the reset anyway.
    always_comb begin
        req_ready_w = '0;
        if ((state_q == S_IDLE) && gnt_found && !reset) begin
            req_ready_w[gnt_idx] = 1'b1;
        end
    end

    assign bus.req_ready = req_ready_w;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.window    = window_q;
    assign bus.res_valid = (state_q == S_REPORT);
    assign bus.res_id    = id_q;
    assign bus.res_count = count_q;
    assign bus.res_hit   = (count_q != '0);

endmodule

// File: tb/tb_seqdet_rr_scheduler.sv
// Testbench for seqdet_rr_scheduler: a queue-based behavioural model predicts
// every output each cycle; directed words with hand-computed counts pin it.
`timescale 1ns/1ps
module tb_seqdet_rr_scheduler;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int P  = 4;
    localparam int C  = 4;
    localparam int C2 = 2;

`ifdef SEQDET_HIST_CLEAR_EN
    localparam int T4B_CNT = 0;
    localparam int T2_5TH  = 2;
`else
    localparam int T4B_CNT = 1;
    localparam int T2_5TH  = 3;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    seqdet_rr_scheduler_if #(.N_REQ(N), .WORD_W(W), .PAT_W(P), .CNT_W(C))  bus  ();
    seqdet_rr_scheduler_if #(.N_REQ(N), .WORD_W(W), .PAT_W(P), .CNT_W(C2)) bus2 ();

    seqdet_rr_scheduler #(.N_REQ(N), .WORD_W(W), .PAT_W(P), .CNT_W(C)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    seqdet_rr_scheduler #(.N_REQ(N), .WORD_W(W), .PAT_W(P), .CNT_W(C2)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2)
    );

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    bit chk_en  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // m_phase: 0 idle, 1..W shifting bit W-m_phase, W+1 reporting.
    int   m_phase = 0;
    int   m_last  = N - 1;
    int   m_id    = 0;
    int   m_count = 0;
    logic [W-1:0] m_word = '0;
    logic [P-1:0] m_pat  = '0;
    bit   hist[$];                 // most recent P detector bits, oldest first

    int glog[$];                   // granted indices (from DUT req_ready)
    int rlog_cnt[$];               // accepted result counts

    always @(negedge clk) begin : monitor
        int g, idx, wv;
        logic [N-1:0] exp_rr;
        bit b;
        if (chk_en) begin
            g = -1;
            if (m_phase == 0 && !reset) begin
                for (int k = 1; k <= N; k++) begin
                    idx = (m_last + k) % N;
                    if (g < 0 && bus.req_valid[idx]) g = idx;
                end
            end
            exp_rr = '0;
            if (g >= 0) exp_rr[g] = 1'b1;
            wv = 0;
            foreach (hist[i]) wv = wv * 2 + int'(hist[i]);

            check("req_ready", bus.req_ready, exp_rr);
            check("busy", bus.busy, m_phase != 0);
            check("res_valid", bus.res_valid, m_phase == W + 1);
            check("window", bus.window, wv);
            if (m_phase == W + 1) begin
                check("res_id", bus.res_id, m_id);
                check("res_count", bus.res_count, m_count);
                check("res_hit", bus.res_hit, m_count != 0);
            end

            for (int k = 0; k < N; k++) if (bus.req_ready[k]) glog.push_back(k);
            if (bus.res_valid && bus.res_ready && !reset) rlog_cnt.push_back(int'(bus.res_count));

            if (reset) begin
                m_phase = 0; m_last = N - 1; m_id = 0; m_count = 0;
                hist.delete();
            end else if (m_phase == 0) begin
                if (g >= 0) begin
                    m_id = g; m_last = g; m_count = 0; m_phase = 1;
                    m_word = bus.req_data[g*W +: W];
                    m_pat  = bus.pattern;
`ifdef SEQDET_HIST_CLEAR_EN
                    hist.delete();
`endif
                end
            end else if (m_phase <= W) begin
                b = m_word[W - m_phase];
                hist.push_back(b);
                if (hist.size() > P) void'(hist.pop_front());
                wv = 0;
                foreach (hist[i]) wv = wv * 2 + int'(hist[i]);
                if (hist.size() == P && wv == int'(m_pat) && m_count < (1 << C) - 1)
                    m_count++;
                m_phase++;
            end else if (bus.res_ready) begin
                m_phase = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_reset();
        reset = 1'b1;
        bus.req_valid = '0;
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic run_word(input int ch, input logic [W-1:0] word, input logic [P-1:0] pat,
                            input int stall, input int exp_cnt, input string name);
        int t_g, t_v;
        bit ok;
        t_g = 0; t_v = 0;
        bus.req_data[ch*W +: W] = word;
        bus.pattern   = pat;
        bus.req_valid = '0;
        bus.req_valid[ch] = 1'b1;
        bus.res_ready = (stall == 0);
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (bus.req_ready[ch]) begin ok = 1; t_g = cyc; end
        end
        check({name, " grant"}, ok, 1);
        @(posedge clk); #1;
        // changes after the grant must not affect the current word
        bus.req_valid[ch] = 1'b0;
        bus.req_data[ch*W +: W] = ~word;
        bus.pattern = ~pat;
        if (stall > 0) bus.req_valid[(ch + 1) % N] = 1'b1;
        ok = 0;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clk);
            if (bus.res_valid) begin ok = 1; t_v = cyc; end
        end
        check({name, " valid"}, ok, 1);
        check({name, " latency"}, t_v - t_g, W + 1);
        check({name, " id"}, bus.res_id, ch);
        check({name, " count"}, bus.res_count, exp_cnt);
        check({name, " hit"}, bus.res_hit, exp_cnt != 0);
        if (stall > 0) begin
            for (int i = 1; i < stall; i++) begin
                @(negedge clk);
                check({name, " stall valid"}, bus.res_valid, 1);
                check({name, " stall id"}, bus.res_id, ch);
                check({name, " stall count"}, bus.res_count, exp_cnt);
                check({name, " stall busy"}, bus.busy, 1);
                check({name, " stall req_ready"}, bus.req_ready, 0);
            end
            @(posedge clk); #1;
            bus.res_ready = 1'b1;
            bus.req_valid = '0;
            @(negedge clk);
            check({name, " accept valid"}, bus.res_valid, 1);
        end
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin : main
        bit ok;
        reset = 1'b1;
        bus.pattern = '0;  bus.req_valid = '0;  bus.req_data = '0;  bus.res_ready = 1'b1;
        bus2.pattern = '0; bus2.req_valid = '0; bus2.req_data = '0; bus2.res_ready = 1'b1;
        @(posedge clk); #1;
        reset  = 1'b0;
        chk_en = 1'b1;

        // reset state
        @(negedge clk);
        check("rst busy", bus.busy, 0);
        check("rst res_valid", bus.res_valid, 0);
        check("rst window", bus.window, 0);
        check("rst res_count", bus.res_count, 0);
        @(posedge clk); #1;

        // 1: single word, two overlapping matches
        run_word(0, 8'b1101_1010, 4'b1101, 0, 2, "t1");

        // 2: all requesters valid, round-robin order 0,1,2,3,0
        do_reset();
        glog.delete(); rlog_cnt.delete();
        bus.req_data  = {8'b0011_0110, 8'b0000_1111, 8'b0000_1101, 8'b1101_1010};
        bus.pattern   = 4'b1101;
        bus.res_ready = 1'b1;
        bus.req_valid = '1;
        for (int i = 0; i < 80 && glog.size() < 5; i++) @(negedge clk);
        @(posedge clk); #1;
        bus.req_valid = '0;
        for (int i = 0; i < 40 && rlog_cnt.size() < 5; i++) @(negedge clk);
        check("t2 grants", glog.size(), 5);
        check("t2 results", rlog_cnt.size(), 5);
        if (glog.size() >= 5 && rlog_cnt.size() >= 5) begin
            check("t2 g0", glog[0], 0); check("t2 g1", glog[1], 1);
            check("t2 g2", glog[2], 2); check("t2 g3", glog[3], 3);
            check("t2 g4", glog[4], 0);
            check("t2 c0", rlog_cnt[0], 2); check("t2 c1", rlog_cnt[1], 1);
            check("t2 c2", rlog_cnt[2], 0); check("t2 c3", rlog_cnt[3], 1);
            check("t2 c4", rlog_cnt[4], T2_5TH);
        end
        @(posedge clk); #1;

        // 3: all-ones word, 5 raw matches; CNT_W=2 instance saturates at 3
        do_reset();
        run_word(0, 8'hFF, 4'b1111, 0, 5, "t3");
        bus2.req_data[7:0] = 8'hFF;
        bus2.pattern   = 4'b1111;
        bus2.req_valid = 4'b0001;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk); ok = bus2.req_ready[0]; end
        check("t3 sat grant", ok, 1);
        @(posedge clk); #1;
        bus2.req_valid = '0;
        ok = 0;
        for (int i = 0; i < 30 && !ok; i++) begin @(negedge clk); ok = bus2.res_valid; end
        check("t3 sat valid", ok, 1);
        check("t3 sat count", bus2.res_count, 3);
        check("t3 sat hit", bus2.res_hit, 1);
        @(posedge clk); #1;

        // 4: history across words
        do_reset();
        run_word(0, 8'b0000_0110, 4'b1101, 0, 0, "t4a");
        run_word(1, 8'b1000_0000, 4'b1101, 0, T4B_CNT, "t4b");

        // 5: consumer stalls 5 cycles, another requester waiting
        run_word(2, 8'b1101_1010, 4'b1101, 5, 2, "t5");

        // 6: reset at 4th shift cycle, pointer returns to requester 0
        bus.req_data[7:0] = 8'b1101_1010;
        bus.pattern   = 4'b1101;
        bus.req_valid = 4'b0001;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk); ok = bus.req_ready[0]; end
        check("t6 grant", ok, 1);
        @(posedge clk); #1;
        bus.req_valid = '0;
        repeat (3) begin @(posedge clk); #1; end
        check("t6 busy before", bus.busy, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("t6 busy", bus.busy, 0);
        check("t6 res_valid", bus.res_valid, 0);
        check("t6 window", bus.window, 0);
        check("t6 req_ready idle", bus.req_ready, 0);
        @(posedge clk); #1;
        bus.req_data[2*W +: W] = 8'b1111_0000;
        bus.req_valid = 4'b0101;
        @(negedge clk);
        check("t6 restart ch0", bus.req_ready, 4'b0001);
        @(posedge clk); #1;
        bus.req_valid = '0;
        ok = 0;
        for (int i = 0; i < 30 && !ok; i++) begin @(negedge clk); ok = bus.res_valid; end
        check("t6 valid", ok, 1);
        check("t6 count", bus.res_count, 2);
        repeat (3) @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
